// File: rtl/control_sequencer.sv
// control_sequencer: hardwired Moore control unit for the 32-bit datapath.
// Steps fetch/decode/execute and drives every datapath and register strobe.
module control_sequencer (
  input  logic       clock,
  input  logic       reset,
  input  logic [4:0] opcode,
  input  logic       con_ff,
  input  logic       stop,
  output logic       PCout,
  output logic       PCin,
  output logic       IncPC,
  output logic       MARin,
  output logic       MDRin,
  output logic       MDRout,
  output logic       Read,
  output logic       Write,
  output logic       IRin,
  output logic       Yin,
  output logic       Zin,
  output logic       Zlowout,
  output logic       Cout,
  output logic       CONin,
  output logic       Gra,
  output logic       Grb,
  output logic       Grc,
  output logic       Rin,
  output logic       Rout,
  output logic       BAout,
  output logic [4:0] alu_op,
  output logic       run
);

  localparam logic [3:0] S_RESET = 4'd0;
  localparam logic [3:0] S_T0    = 4'd1;
  localparam logic [3:0] S_T1    = 4'd2;
  localparam logic [3:0] S_T2    = 4'd3;
  localparam logic [3:0] S_T3    = 4'd4;
  localparam logic [3:0] S_T4    = 4'd5;
  localparam logic [3:0] S_T5    = 4'd6;
  localparam logic [3:0] S_T6    = 4'd7;
  localparam logic [3:0] S_T7    = 4'd8;
  localparam logic [3:0] S_HALT  = 4'd9;

  localparam logic [4:0] ALU_ADD = 5'b00011;

  logic [3:0] state_q, state_d;
  logic       last;

  logic is_alu, is_addi, is_ldi, is_ld, is_st;
  logic is_br, is_halt, is_nop, is_mem, is_short;

  assign is_alu   = opcode inside {5'b00011, 5'b00100,
                                   5'b00101, 5'b00110};
  assign is_addi  = (opcode == 5'b01100);
  assign is_ldi   = (opcode == 5'b00001);
  assign is_ld    = (opcode == 5'b00000);
  assign is_st    = (opcode == 5'b00010);
  assign is_br    = (opcode == 5'b10010);
  assign is_halt  = (opcode == 5'b11011);
  assign is_mem   = is_ld | is_st;
  assign is_short = is_alu | is_addi | is_ldi;
  assign is_nop   = ~(is_short | is_mem | is_br | is_halt);

  // State register; reset aborts any step immediately
  always_ff @(posedge clock) begin
    if (reset) state_q <= S_RESET;
    else       state_q <= state_d;
  end

  // Step sequencing; stop only redirects the final step of an instruction
  always_comb begin
    state_d = state_q;
    last    = 1'b0;
    unique case (state_q)
      S_RESET: state_d = S_T0;
      S_T0:    state_d = S_T1;
      S_T1:    state_d = S_T2;
      S_T2:    state_d = S_T3;
      S_T3: begin
        if (is_halt)     state_d = S_HALT;
        else if (is_nop) last    = 1'b1;
        else             state_d = S_T4;
      end
      S_T4:    state_d = S_T5;
      S_T5: begin
        if (is_short) last    = 1'b1;
        else          state_d = S_T6;
      end
      S_T6: begin
        if (is_br) last    = 1'b1;
        else       state_d = S_T7;
      end
      S_T7:    last    = 1'b1;
      S_HALT:  state_d = S_HALT;
      default: state_d = S_RESET;
    endcase
    if (last) state_d = stop ? S_HALT : S_T0;
  end

  // Strobe generation from current step and opcode class
  always_comb begin
    PCout = 1'b0; PCin = 1'b0; IncPC = 1'b0;
    MARin = 1'b0; MDRin = 1'b0; MDRout = 1'b0;
    Read = 1'b0; Write = 1'b0; IRin = 1'b0;
    Yin = 1'b0; Zin = 1'b0; Zlowout = 1'b0;
    Cout = 1'b0; CONin = 1'b0;
    Gra = 1'b0; Grb = 1'b0; Grc = 1'b0;
    Rin = 1'b0; Rout = 1'b0; BAout = 1'b0;
    alu_op = 5'b00000;
    run = 1'b0;
    unique case (state_q)
      S_T0: begin
        run = 1'b1;
        PCout = 1'b1; MARin = 1'b1;
        IncPC = 1'b1; Zin = 1'b1;
      end
      S_T1: begin
        run = 1'b1;
        Zlowout = 1'b1; PCin = 1'b1;
        Read = 1'b1; MDRin = 1'b1;
      end
      S_T2: begin
        run = 1'b1;
        MDRout = 1'b1; IRin = 1'b1;
      end
      S_T3: begin
        run = 1'b1;
        if (is_alu | is_addi) begin
          Grb = 1'b1; Rout = 1'b1; Yin = 1'b1;
        end else if (is_ldi | is_mem) begin
          Grb = 1'b1; BAout = 1'b1; Yin = 1'b1;
        end else if (is_br) begin
          Gra = 1'b1; Rout = 1'b1; CONin = 1'b1;
        end
      end
      S_T4: begin
        run = 1'b1;
        if (is_alu) begin
          Grc = 1'b1; Rout = 1'b1; Zin = 1'b1;
          alu_op = opcode;
        end else if (is_addi | is_ldi | is_mem) begin
          Cout = 1'b1; Zin = 1'b1;
          alu_op = ALU_ADD;
        end else if (is_br) begin
          PCout = 1'b1; Yin = 1'b1;
        end
      end
      S_T5: begin
        run = 1'b1;
        if (is_short) begin
          Zlowout = 1'b1; Gra = 1'b1; Rin = 1'b1;
        end else if (is_mem) begin
          Zlowout = 1'b1; MARin = 1'b1;
        end else if (is_br) begin
          Cout = 1'b1; Zin = 1'b1;
          alu_op = ALU_ADD;
        end
      end
      S_T6: begin
        run = 1'b1;
        if (is_ld) begin
          Read = 1'b1; MDRin = 1'b1;
        end else if (is_st) begin
          Gra = 1'b1; Rout = 1'b1; MDRin = 1'b1;
        end else if (is_br) begin
          Zlowout = 1'b1; PCin = con_ff;
        end
      end
      S_T7: begin
        run = 1'b1;
        if (is_ld) begin
          MDRout = 1'b1; Gra = 1'b1; Rin = 1'b1;
        end else if (is_st) begin
          Write = 1'b1;
        end
      end
      default: run = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_control_sequencer.sv
// tb_control_sequencer: directed scenario bench for control_sequencer.
// Each task walks an instruction step by step against hand tables.
module tb_control_sequencer;

  localparam logic [19:0] PCOUT  = 20'h80000;
  localparam logic [19:0] PCIN   = 20'h40000;
  localparam logic [19:0] INCPC  = 20'h20000;
  localparam logic [19:0] MARIN  = 20'h10000;
  localparam logic [19:0] MDRIN  = 20'h08000;
  localparam logic [19:0] MDROUT = 20'h04000;
  localparam logic [19:0] READ   = 20'h02000;
  localparam logic [19:0] WRITE  = 20'h01000;
  localparam logic [19:0] IRIN   = 20'h00800;
  localparam logic [19:0] YIN    = 20'h00400;
  localparam logic [19:0] ZIN    = 20'h00200;
  localparam logic [19:0] ZLOW   = 20'h00100;
  localparam logic [19:0] COUT   = 20'h00080;
  localparam logic [19:0] CONIN  = 20'h00040;
  localparam logic [19:0] GRA    = 20'h00020;
  localparam logic [19:0] GRB    = 20'h00010;
  localparam logic [19:0] GRC    = 20'h00008;
  localparam logic [19:0] RIN    = 20'h00004;
  localparam logic [19:0] ROUT   = 20'h00002;
  localparam logic [19:0] BAOUT  = 20'h00001;

  localparam logic [19:0] F0 = PCOUT | MARIN | INCPC | ZIN;
  localparam logic [19:0] F1 = ZLOW | PCIN | READ | MDRIN;
  localparam logic [19:0] F2 = MDROUT | IRIN;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [4:0] opcode = 5'b0;
  logic       con_ff = 1'b0;
  logic       stop = 1'b0;
  logic PCout, PCin, IncPC, MARin, MDRin, MDRout, Read, Write;
  logic IRin, Yin, Zin, Zlowout, Cout, CONin;
  logic Gra, Grb, Grc, Rin, Rout, BAout;
  logic [4:0] alu_op;
  logic       run;
  logic [19:0] strb;

  int errors = 0;
  int checks = 0;

  control_sequencer dut (
    .clock(clock), .reset(reset), .opcode(opcode),
    .con_ff(con_ff), .stop(stop),
    .PCout(PCout), .PCin(PCin), .IncPC(IncPC),
    .MARin(MARin), .MDRin(MDRin), .MDRout(MDRout),
    .Read(Read), .Write(Write), .IRin(IRin),
    .Yin(Yin), .Zin(Zin), .Zlowout(Zlowout),
    .Cout(Cout), .CONin(CONin),
    .Gra(Gra), .Grb(Grb), .Grc(Grc),
    .Rin(Rin), .Rout(Rout), .BAout(BAout),
    .alu_op(alu_op), .run(run)
  );

  assign strb = {PCout, PCin, IncPC, MARin, MDRin, MDRout,
                 Read, Write, IRin, Yin, Zin, Zlowout,
                 Cout, CONin, Gra, Grb, Grc, Rin, Rout, BAout};

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    checks++;
    if (strb !== 20'h0 || alu_op !== 5'd0 || run !== 1'b0) begin
      errors++;
      $display("FAIL reset_state got %h/%h/%b want 0/0/0",
               strb, alu_op, run);
    end
    reset = 1'b0;
    tick();
    checks++;
    if (strb !== F0 || run !== 1'b1) begin
      errors++;
      $display("FAIL reset_first_t0 got %h/%b want %h/1",
               strb, run, F0);
    end
  endtask

  task automatic test_alu();
    logic [4:0]  ops [3];
    logic [19:0] e [6];
    ops = '{5'b00011, 5'b00100, 5'b00110};
    e = '{F0, F1, F2, GRB | ROUT | YIN,
          GRC | ROUT | ZIN, ZLOW | GRA | RIN};
    for (int i = 0; i < 3; i++) begin
      opcode = ops[i];
      for (int k = 0; k < 6; k++) begin
        checks++;
        if (strb !== e[k] || run !== 1'b1) begin
          errors++;
          $display("FAIL alu%0h T%0d got %h/%b want %h/1",
                   ops[i], k, strb, run, e[k]);
        end
        checks++;
        if (alu_op !== ((k == 4) ? ops[i] : 5'd0)) begin
          errors++;
          $display("FAIL alu%0h T%0d alu_op got %h",
                   ops[i], k, alu_op);
        end
        tick();
      end
      checks++;
      if (strb !== F0) begin
        errors++;
        $display("FAIL alu%0h period got %h want %h",
                 ops[i], strb, F0);
      end
    end
  endtask

  task automatic test_imm();
    logic [4:0]  ops [2];
    logic [19:0] e3 [2];
    logic [19:0] e [6];
    ops = '{5'b01100, 5'b00001};
    e3 = '{GRB | ROUT | YIN, GRB | BAOUT | YIN};
    for (int i = 0; i < 2; i++) begin
      opcode = ops[i];
      e = '{F0, F1, F2, e3[i], COUT | ZIN,
            ZLOW | GRA | RIN};
      for (int k = 0; k < 6; k++) begin
        checks++;
        if (strb !== e[k] ||
            alu_op !== ((k == 4) ? 5'b00011 : 5'd0)) begin
          errors++;
          $display("FAIL imm%0h T%0d got %h/%h want %h",
                   ops[i], k, strb, alu_op, e[k]);
        end
        tick();
      end
      checks++;
      if (strb !== F0) begin
        errors++;
        $display("FAIL imm%0h period got %h want %h",
                 ops[i], strb, F0);
      end
    end
  endtask

  task automatic test_mem();
    logic [4:0]  ops [2];
    logic [19:0] e6 [2];
    logic [19:0] e7 [2];
    logic [19:0] e [8];
    ops = '{5'b00000, 5'b00010};
    e6 = '{READ | MDRIN, GRA | ROUT | MDRIN};
    e7 = '{MDROUT | GRA | RIN, WRITE};
    for (int i = 0; i < 2; i++) begin
      opcode = ops[i];
      e = '{F0, F1, F2, GRB | BAOUT | YIN, COUT | ZIN,
            ZLOW | MARIN, e6[i], e7[i]};
      for (int k = 0; k < 8; k++) begin
        checks++;
        if (strb !== e[k] ||
            alu_op !== ((k == 4) ? 5'b00011 : 5'd0)) begin
          errors++;
          $display("FAIL mem%0h T%0d got %h/%h want %h",
                   ops[i], k, strb, alu_op, e[k]);
        end
        tick();
      end
      checks++;
      if (strb !== F0) begin
        errors++;
        $display("FAIL mem%0h period got %h want %h",
                 ops[i], strb, F0);
      end
    end
  endtask

  task automatic test_br();
    logic [19:0] e [7];
    opcode = 5'b10010;
    for (int c = 0; c < 2; c++) begin
      con_ff = c[0];
      e = '{F0, F1, F2, GRA | ROUT | CONIN, PCOUT | YIN,
            COUT | ZIN, (c == 1) ? (ZLOW | PCIN) : ZLOW};
      for (int k = 0; k < 7; k++) begin
        checks++;
        if (strb !== e[k] ||
            alu_op !== ((k == 5) ? 5'b00011 : 5'd0)) begin
          errors++;
          $display("FAIL br con%0d T%0d got %h/%h want %h",
                   c, k, strb, alu_op, e[k]);
        end
        tick();
      end
      checks++;
      if (strb !== F0) begin
        errors++;
        $display("FAIL br con%0d period got %h want %h",
                 c, strb, F0);
      end
    end
    con_ff = 1'b0;
  endtask

  task automatic test_halt();
    int bad;
    opcode = 5'b11011;
    tick();
    tick();
    tick();
    checks++;
    if (strb !== 20'h0 || run !== 1'b1) begin
      errors++;
      $display("FAIL halt_T3 got %h/%b want 0/1", strb, run);
    end
    bad = 0;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (strb !== 20'h0 || alu_op !== 5'd0 || run !== 1'b0)
        bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL halt_hold got %0d bad cycles want 0", bad);
    end
    reset = 1'b1;
    tick();
    checks++;
    if (strb !== 20'h0 || run !== 1'b0) begin
      errors++;
      $display("FAIL halt_reset got %h/%b want 0/0", strb, run);
    end
    reset = 1'b0;
    tick();
    checks++;
    if (strb !== F0 || run !== 1'b1) begin
      errors++;
      $display("FAIL halt_restart got %h/%b want %h/1",
               strb, run, F0);
    end
  endtask

  task automatic test_stop();
    opcode = 5'b00011;
    tick();
    stop = 1'b1;
    tick();
    checks++;
    if (strb !== F2 || run !== 1'b1) begin
      errors++;
      $display("FAIL stop_midfetch got %h/%b want %h/1",
               strb, run, F2);
    end
    tick();
    tick();
    tick();
    checks++;
    if (strb !== (ZLOW | GRA | RIN) || run !== 1'b1) begin
      errors++;
      $display("FAIL stop_T5 got %h/%b want %h/1",
               strb, run, ZLOW | GRA | RIN);
    end
    tick();
    checks++;
    if (strb !== 20'h0 || run !== 1'b0) begin
      errors++;
      $display("FAIL stop_halt got %h/%b want 0/0", strb, run);
    end
    stop = 1'b0;
    tick();
    checks++;
    if (run !== 1'b0) begin
      errors++;
      $display("FAIL stop_hold got run %b want 0", run);
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid();
    logic [19:0] e [4];
    opcode = 5'b00000;
    for (int k = 0; k < 5; k++) tick();
    checks++;
    if (strb !== (ZLOW | MARIN)) begin
      errors++;
      $display("FAIL abort_T5 got %h want %h",
               strb, ZLOW | MARIN);
    end
    reset = 1'b1;
    tick();
    checks++;
    if (strb !== 20'h0 || alu_op !== 5'd0 || run !== 1'b0) begin
      errors++;
      $display("FAIL abort_reset got %h/%h/%b want 0/0/0",
               strb, alu_op, run);
    end
    reset = 1'b0;
    tick();
    opcode = 5'b11111;
    e = '{F0, F1, F2, 20'h0};
    for (int r = 0; r < 2; r++) begin
      for (int k = 0; k < 4; k++) begin
        checks++;
        if (strb !== e[k] || run !== 1'b1) begin
          errors++;
          $display("FAIL unknown T%0d got %h/%b want %h/1",
                   k, strb, run, e[k]);
        end
        tick();
      end
    end
    checks++;
    if (strb !== F0) begin
      errors++;
      $display("FAIL unknown period got %h want %h", strb, F0);
    end
  endtask

  initial begin
    test_reset();
    test_alu();
    test_imm();
    test_mem();
    test_br();
    test_halt();
    test_stop();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
